// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader's control, byte-stream and instruction-memory write
// signals.
//   start    : one-cycle load request
//   in_data  : program byte stream, in_valid / in_ready handshake
//   wr_en    : one-cycle instruction-memory write strobe (wr_addr, wr_data)
//   busy     : loader is not idle
//   done     : one-cycle end-of-load pulse
//   err      : sticky error flag
// The slave modport is the loader; the master modport is the byte source
// and load controller.
// -----------------------------------------------------------------------------
interface imem_loader_if;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a length-prefixed, checksummed program over a byte stream and
// writes it word by word into an instruction memory.
// Stream format: N, then N little-endian 32-bit words, then an XOR checksum
// over every preceding byte of the load.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : imem_loader_if.slave (start, byte stream, write port, status)
// All outputs are registered; each is loaded from the value it must show in
// the state being entered, so it lines up exactly with that state.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd4,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int unsigned MAX_WORDS = 32'd16
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    // Running XOR checksum update.
    function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] b);
        return csum ^ b;
    endfunction

    logic [2:0]  state_r,    state_s;
    logic [7:0]  len_r,      len_s;
    logic [7:0]  word_cnt_r, word_cnt_s;
    logic [1:0]  byte_cnt_r, byte_cnt_s;
    logic [31:0] asm_r,      asm_s;
    logic [7:0]  csum_r,     csum_s;
    logic        err_r,      err_s;
    logic [31:0] wr_addr_r,  wr_addr_s;
    logic [31:0] wr_data_r,  wr_data_s;
    logic        in_ready_r, in_ready_s;
    logic        wr_en_r,    wr_en_s;
    logic        busy_r,     busy_s;
    logic        done_r,     done_s;
    logic        accept_s;
    logic [31:0] assembled_s;

    // in_ready_r always equals the decode of the current state.
    assign accept_s    = bus.in_valid & in_ready_r;
    // Little-endian assembly: shifting bytes in from the top leaves the
    // first byte in bits [7:0] after four bytes.
    assign assembled_s = {bus.in_data, asm_r[31:8]};

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_s    = state_r;
        len_s      = len_r;
        word_cnt_s = word_cnt_r;
        byte_cnt_s = byte_cnt_r;
        asm_s      = asm_r;
        csum_s     = csum_r;
        err_s      = err_r;
        wr_addr_s  = wr_addr_r;
        wr_data_s  = wr_data_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    err_s      = 1'b0;
                    word_cnt_s = 8'd0;
                    byte_cnt_s = 2'd0;
                    csum_s     = 8'd0;
                    state_s    = ST_LEN;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    len_s  = bus.in_data;
                    csum_s = csum_update(csum_r, bus.in_data);
                    if (bus.in_data == 8'd0) begin
                        state_s = ST_CSUM;
                    end else if ({24'd0, bus.in_data} > MAX_WORDS) begin
                        err_s   = 1'b1;
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    asm_s      = assembled_s;
                    csum_s     = csum_update(csum_r, bus.in_data);
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        wr_addr_s = BASE_ADDR + ({24'd0, word_cnt_r} * ADDR_STEP);
                        wr_data_s = assembled_s;
                        state_s   = ST_WRITE;
                    end else begin
                        state_s   = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                word_cnt_s = word_cnt_r + 8'd1;
                if ((word_cnt_r + 8'd1) < len_r) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    if (bus.in_data != csum_r) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_CSUM;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        in_ready_s = (state_s == ST_LEN) || (state_s == ST_DATA) || (state_s == ST_CSUM);
        wr_en_s    = (state_s == ST_WRITE);
        busy_s     = (state_s != ST_IDLE);
        done_s     = (state_s == ST_FIN);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            len_r      <= 8'd0;
            word_cnt_r <= 8'd0;
            byte_cnt_r <= 2'd0;
            asm_r      <= 32'd0;
            csum_r     <= 8'd0;
            err_r      <= 1'b0;
            wr_addr_r  <= 32'd0;
            wr_data_r  <= 32'd0;
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            len_r      <= len_s;
            word_cnt_r <= word_cnt_s;
            byte_cnt_r <= byte_cnt_s;
            asm_r      <= asm_s;
            csum_r     <= csum_s;
            err_r      <= err_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            in_ready_r <= in_ready_s;
            wr_en_r    <= wr_en_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.wr_en    = wr_en_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

endmodule
